regfile_seq: RTL

REGFILE_SEQ -- requirements
Module: regfile_seq

---
 rtl/regfile_seq_pkg.sv | 30 +++
 rtl/regfile_seq.sv | 133 +++++++++++++
 2 files changed

// File: rtl/regfile_seq_pkg.sv
// Shared widths, register-file write-command codes, Q-phase constants and
// sequencer state encodings for the core/debug register-file sequencer.
package regfile_seq_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 5;

    typedef enum logic [2:0] {
        WR_NONE        = 3'b000,
        WR_STATUS      = 3'b001,
        WR_FILE        = 3'b010,
        WR_FILE_STATUS = 3'b011,
        WR_FSR         = 3'b100
    } wr_cmd_e;

    typedef enum logic [1:0] {
        Q1 = 2'd0,
        Q2 = 2'd1,
        Q3 = 2'd2,
        Q4 = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALT   = 2'd1,
        DBG_RD = 2'd2,
        DBG_WR = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_seq.sv
// Four-phase register-file sequencer with skip/branch flush, debug halt and
// two-cycle debug read/write access to the file.
module regfile_seq
    import regfile_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] coreAddr,
    input  logic [DATA_WIDTH-1:0] coreData,
    input  logic [2:0]            coreWrCmd,
    input  logic                  skipReq,
    input  logic                  branchReq,
    input  logic                  haltReq,
    input  logic                  dbgReq,
    input  logic                  dbgWr,
    input  logic [ADDR_WIDTH-1:0] dbgAddr,
    input  logic [DATA_WIDTH-1:0] dbgWdata,
    input  logic [DATA_WIDTH-1:0] regfileOut,
    output logic [ADDR_WIDTH-1:0] fileAddr,
    output logic [DATA_WIDTH-1:0] writeDataIn,
    output logic [2:0]            writeCommand,
    output logic                  Read_En,
    output logic [1:0]            qPhase,
    output logic                  fetchEn,
    output logic                  pcInc,
    output logic                  flush,
    output logic                  halted,
    output logic                  dbgAck,
    output logic [DATA_WIDTH-1:0] dbgRdata
);

    state_e                state_q, state_d;
    phase_e                phase_q, phase_d;
    logic                  flush_q, flush_d;
    logic                  step_q, step_d;
    logic                  run_d;
    logic                  read_en_d;
    logic [2:0]            wr_cmd_d;
    logic                  fetch_d;
    logic                  ack_d;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        flush_d = flush_q;
        step_d  = 1'b0;
        rdata_d = dbgRdata;
        unique case (state_q)
            RUN: begin
                if (phase_q == Q4) begin
                    phase_d = Q1;
                    // A flushed Q4 cannot arm another flush.
                    flush_d = flush_q ? 1'b0 : (skipReq | branchReq);
                    if (haltReq)
                        state_d = HALT;
                end else begin
                    phase_d = phase_e'(phase_q + 2'd1);
                end
            end
            HALT: begin
                if (dbgReq)
                    state_d = dbgWr ? DBG_WR : DBG_RD;
                else if (!haltReq)
                    state_d = RUN;
            end
            DBG_RD: begin
                if (!step_q) begin
                    step_d  = 1'b1;
                    rdata_d = regfileOut;
                end else begin
                    state_d = HALT;
                end
            end
            DBG_WR: begin
                if (!step_q)
                    step_d = 1'b1;
                else
                    state_d = HALT;
            end
            default: state_d = RUN;
        endcase

        // Strobes are registered from the next-state view so they line up
        // with the phase they belong to without any combinational glitch.
        run_d     = (state_d == RUN);
        read_en_d = (run_d && phase_d == Q2 && !flush_d) ||
                    (state_d == DBG_RD && !step_d);
        if (run_d && phase_d == Q4 && !flush_d)
            wr_cmd_d = coreWrCmd;
        else if (state_d == DBG_WR && !step_d)
            wr_cmd_d = WR_FILE;
        else
            wr_cmd_d = WR_NONE;
        fetch_d = run_d && phase_d == Q4;
        ack_d   = (state_d == DBG_RD || state_d == DBG_WR) && step_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            phase_q      <= Q1;
            flush_q      <= 1'b1;
            step_q       <= 1'b0;
            Read_En      <= 1'b0;
            writeCommand <= WR_NONE;
            fetchEn      <= 1'b0;
            pcInc        <= 1'b0;
            halted       <= 1'b0;
            dbgAck       <= 1'b0;
            dbgRdata     <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            flush_q      <= flush_d;
            step_q       <= step_d;
            Read_En      <= read_en_d;
            writeCommand <= wr_cmd_d;
            fetchEn      <= fetch_d;
            pcInc        <= fetch_d;
            halted       <= !run_d;
            dbgAck       <= ack_d;
            dbgRdata     <= rdata_d;
        end
    end

    assign qPhase = phase_q;
    assign flush  = flush_q;

    assign fileAddr    = (state_q == RUN) ? coreAddr : dbgAddr;
    assign writeDataIn = (state_q == RUN) ? coreData : dbgWdata;

endmodule
